prescaler_bank: RTL
===================

# prescaler_bank

Multi-channel programmable prescaler that generates clock-enable ticks and divided square-wave levels from the single system clock. It generalises the fixed single-divider prescaler: each channel has a runtime-loadable divide value, double-buffered so changes take effect glitch-free. Each channel can free-run or fire once. A global sync re-aligns all channels. It feeds game-timing logic (ball/paddle step rates, display refresh, sound) with phase-coherent enables.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 16: counter and divide-value width in bits.
- DEFAULT_DIV, 128: divide value loaded into every channel at reset. Must fit in WIDTH bits.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global count enable. Low freezes all channels.
- sync  input  1  one-cycle strobe that restarts all channels phase-aligned.
- load  input  CHANNELS  per-channel strobe that writes div_in to that channel's shadow register.
- div_in  input  WIDTH  divide value shared by all load strobes. Channel period is div_in+1 cycles.
- oneshot  input  CHANNELS  per-channel mode: 0 = free-run, 1 = one-shot.
- tick  output  CHANNELS  registered one-cycle pulse at each terminal count.
- level  output  CHANNELS  registered; toggles at each terminal count, giving a 50% duty square wave of period 2*(div+1).
- done  output  CHANNELS  registered; high while a one-shot channel is stopped.

## Operation
- Per-channel state: counter[WIDTH], active_div, shadow_div, pending flag, tick, level, done.
- Reset (async) sets:
  - counter=0, active_div=shadow_div=DEFAULT_DIV, pending=0;
  - tick=0, level=0, done=0 on every channel.
- Terminal count (TC): counter==active_div while running, en=1, sync=0. On TC:
  - counter<=0, tick<=1, level<=~level;
  - if pending: active_div<=shadow_div and pending<=0;
  - if oneshot=1 (sampled at TC): done<=1.
- Not at TC: counter<=counter+1, tick<=0.
- Stopped channel (done=1): counter holds 0, tick=0, level holds.
- Load: load[i]=1 sets shadow_div[i]<=div_in and pending[i]<=1.
  - A load in the TC cycle lands in the shadow only; it is applied at the next TC.
  - A repeated load before TC overwrites the shadow; last value wins.
  - A load on a done channel also applies active_div<=div_in immediately, clears pending and done, and restarts the count from 0.
- Sync (en ignored): for all channels, counter<=0, tick<=0, level<=0, done<=0.
  - Any pending shadow is applied to active_div.
  - A load in the same cycle applies div_in directly to active_div.
- en=0 (no sync): counters, levels, done and pending hold; tick<=0. Loads are still accepted into the shadow.
- Priority: rst > sync > (load-on-done restart) > en=0 > TC > increment.
- div=0: tick is high every enabled cycle and level toggles every cycle.
- Counter never exceeds active_div because active_div changes only at TC, sync or a restart, all of which zero the counter. Maximum divide is 2^WIDTH cycles.

## Timing
- Tick latency: with en held high from reset release, the first tick is asserted after rising edge active_div+1. The tick is then periodic with period active_div+1 cycles.
- Output relationships:
  - tick, level and done change on the same edge;
  - done rises together with the final tick;
  - all outputs are registered, with no combinational paths from inputs.
- After sync at edge N, the first tick of every channel occurs at edge N+div+1. Channels sharing a div are exactly aligned.
- A load restart on a done channel at edge N gives a first tick at edge N+div_in+1.
- An en low for k cycles delays all subsequent ticks by exactly k cycles.

## Test plan
- Reset, en=1, no loads, DEFAULT_DIV=128 -> each tick at edges 129, 258, 387; level period 258 cycles; done stays 0.
- load[0] with div_in=3 mid-count, then next TC -> old period is completed first; afterwards tick[0] every 4 cycles and level[0] period 8; other channels unaffected.
- oneshot[1]=1, load div_in=5 after done -> exactly one tick 6 cycles after the restart, done[1]=1, no further ticks; a second load re-arms it.
- Channels loaded with 2 and 5, then sync -> all counters zero, level=0; ticks at N+3 and N+6, then every 3 and every 6 cycles.
- div=0 on channel 2 -> tick[2] high every cycle and level[2] toggles each cycle. Drop en for 4 cycles -> ticks are absent for 4 cycles and the phase shifts by 4 on all channels.
- Assert rst mid-count, asynchronously between edges -> outputs clear immediately and active_div returns to 128; the first post-reset tick comes at edge 129.

Source files
------------

// File: rtl/prescaler_bank.sv
// Bank of programmable clock-enable prescalers. Each lane owns a double-buffered
// divide value, free-run/one-shot modes, and shares the global en/sync strobes.

module prescaler_lane #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             level,
  output logic             done
);
  localparam logic [WIDTH-1:0] DEF = DEFAULT_DIV[WIDTH-1:0];

  logic [WIDTH-1:0] cnt, active, shadow;
  logic             pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      active  <= DEF;
      shadow  <= DEF;
      pending <= 1'b0;
      tick    <= 1'b0;
      level   <= 1'b0;
      done    <= 1'b0;
    end else if (sync) begin
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
      done  <= 1'b0;
      if (load) begin
        active  <= div_in;
        shadow  <= div_in;
        pending <= 1'b0;
      end else if (pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end else if (load && done) begin
      // re-arm a stopped one-shot: new divide takes effect immediately
      active  <= div_in;
      shadow  <= div_in;
      pending <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      tick    <= 1'b0;
    end else begin
      if (!en) begin
        tick <= 1'b0;
      end else if (done) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt == active) begin
        cnt   <= '0;
        tick  <= 1'b1;
        level <= ~level;
        if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
        if (oneshot) done <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
      // a load landing on the TC cycle must stay pending for the next TC
      if (load) begin
        shadow  <= div_in;
        pending <= 1'b1;
      end
    end
  end
endmodule

module prescaler_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic [CHANNELS-1:0] load,
  input  logic [WIDTH-1:0]    div_in,
  input  logic [CHANNELS-1:0] oneshot,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] done
);
  prescaler_lane #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_lane [CHANNELS-1:0] (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .load   (load),
    .oneshot(oneshot),
    .div_in (div_in),
    .tick   (tick),
    .level  (level),
    .done   (done)
  );
endmodule
